alu_mdu: RTL and testbench

Parametrised iterative multiply/divide unit for the RV M-extension. It sits beside the single-cycle ALU in the execute stage. It accepts one operation per request through a valid/ready handshake and computes it over DATA_WIDTH+1 cycles using a radix-2 shift-add multiplier or a restoring divider. It holds the result behind an output valid/ready handshake. Divide-by-zero and signed overflow complete on a one-cycle fast path, and a flush input aborts work in flight.

---
 rtl/alu_mdu.sv | 167 ++++++++++++++++
 tb/tb_alu_mdu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Iterative RV M-extension multiply/divide: radix-2 shift-add multiply, restoring divide, DATA_WIDTH+1 cycles.
// Divide-by-zero and signed overflow take a one-cycle fast path; the result is held in DONE until consumed.
module alu_mdu #(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mdu_flush,
  input  logic                  i_mdu_valid,
  output logic                  o_mdu_ready,
  input  logic [2:0]            i_mdu_type,
  input  logic [DATA_WIDTH-1:0] i_mdu_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_mdu_rs2_data,
  output logic                  o_mdu_res_valid,
  input  logic                  i_mdu_res_ready,
  output logic [DATA_WIDTH-1:0] o_mdu_res,
  output logic                  o_mdu_zero,
  output logic                  o_mdu_neg,
  output logic                  o_mdu_busy
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state;
  logic [2:0]           op;
  logic [2*W-1:0]       acc;
  logic [W-1:0]         opa;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 sign;
  logic                 fast;
  logic [W-1:0]         res;

  logic           is_div;
  logic           rs1_signed;
  logic           rs2_signed;
  logic           s1;
  logic           s2;
  logic [W-1:0]   mag1;
  logic [W-1:0]   mag2;
  logic           div_zero;
  logic           div_ovf;
  logic           sign_in;
  logic [W-1:0]   fast_res;

  always_comb begin
    is_div     = i_mdu_type[2];
    rs1_signed = (i_mdu_type == 3'd0) || (i_mdu_type == 3'd1) || (i_mdu_type == 3'd2) ||
                 (i_mdu_type == 3'd4) || (i_mdu_type == 3'd6);
    rs2_signed = (i_mdu_type == 3'd0) || (i_mdu_type == 3'd1) ||
                 (i_mdu_type == 3'd4) || (i_mdu_type == 3'd6);
    s1         = rs1_signed & i_mdu_rs1_data[W-1];
    s2         = rs2_signed & i_mdu_rs2_data[W-1];
    mag1       = s1 ? -i_mdu_rs1_data : i_mdu_rs1_data;
    mag2       = s2 ? -i_mdu_rs2_data : i_mdu_rs2_data;
    div_zero   = is_div && (i_mdu_rs2_data == '0);
    div_ovf    = is_div && !i_mdu_type[0] &&
                 (i_mdu_rs1_data == {1'b1, {(W-1){1'b0}}}) && (i_mdu_rs2_data == '1);
    // Remainder takes the dividend's sign; product and quotient take the XOR.
    sign_in    = (is_div && i_mdu_type[1]) ? s1 : (s1 ^ s2);
    fast_res   = '0;
    if (div_zero)
      fast_res = i_mdu_type[1] ? i_mdu_rs1_data : '1;
    else if (div_ovf)
      fast_res = i_mdu_type[1] ? '0 : i_mdu_rs1_data;
  end

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_shift;
  logic [W:0]     div_diff;
  logic           div_ge;
  logic [2*W-1:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opa} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc[W-1:1]};
    // Shifted remainder needs one extra bit before the trial subtraction.
    div_shift = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_shift - {1'b0, opa};
    div_ge    = div_shift >= {1'b0, opa};
    div_next  = div_ge ? {div_diff[W-1:0], acc[W-2:0], 1'b1}
                       : {div_shift[W-1:0], acc[W-2:0], 1'b0};
  end

  logic [2*W-1:0] prod_f;
  logic [W-1:0]   quot_f;
  logic [W-1:0]   rem_f;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod_f = sign ? -acc : acc;
    quot_f = sign ? -acc[W-1:0] : acc[W-1:0];
    rem_f  = sign ? -acc[2*W-1:W] : acc[2*W-1:W];
    case (op)
      3'd0:             fix_res = prod_f[W-1:0];
      3'd1, 3'd2, 3'd3: fix_res = prod_f[2*W-1:W];
      3'd4, 3'd5:       fix_res = quot_f;
      default:          fix_res = rem_f;
    endcase
    if (fast)
      fix_res = acc[W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      op    <= '0;
      acc   <= '0;
      opa   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      fast  <= 1'b0;
      res   <= '0;
    end else if (i_mdu_flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_mdu_valid) begin
            op   <= i_mdu_type;
            cnt  <= '0;
            sign <= sign_in;
            // Fast-path result rides through FIX in the low half of acc.
            if (div_zero || div_ovf) begin
              fast  <= 1'b1;
              acc   <= {{W{1'b0}}, fast_res};
              opa   <= '0;
              state <= FIX;
            end else begin
              fast  <= 1'b0;
              acc   <= {{W{1'b0}}, is_div ? mag1 : mag2};
              opa   <= is_div ? mag2 : mag1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= op[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_WIDTH'(W - 1))
            state <= FIX;
        end
        FIX: begin
          res   <= fix_res;
          state <= DONE;
        end
        DONE: begin
          if (i_mdu_res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mdu_ready     = (state == IDLE);
  assign o_mdu_res_valid = (state == DONE);
  assign o_mdu_busy      = (state != IDLE);
  assign o_mdu_res       = res;
  assign o_mdu_zero      = (res == '0);
  assign o_mdu_neg       = res[W-1];

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at DATA_WIDTH=32 with hand-computed results and latencies.
module tb_alu_mdu;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_type;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res;
  logic        zero;
  logic        neg;
  logic        busy;

  int checks;
  int failures;

  alu_mdu #(.DATA_WIDTH(32)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_mdu_flush     (flush),
    .i_mdu_valid     (req_valid),
    .o_mdu_ready     (req_ready),
    .i_mdu_type      (req_type),
    .i_mdu_rs1_data  (rs1),
    .i_mdu_rs2_data  (rs2),
    .o_mdu_res_valid (res_valid),
    .i_mdu_res_ready (res_ready),
    .o_mdu_res       (res),
    .o_mdu_zero      (zero),
    .o_mdu_neg       (neg),
    .o_mdu_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, presents the request and returns just after the accept edge.
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    chk("issue_ready", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_type  = t;
    rs1       = a;
    rs2       = b;
    tick();
    req_valid = 1'b0;
    rs1       = $urandom;
    rs2       = $urandom;
    req_type  = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(t, a, b);
    wait_res(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, {32'd0, res}, {32'd0, exp_res});
    chk({tag, "_neg"}, {63'd0, neg}, {63'd0, exp_res[31]});
    chk({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_res == 32'd0});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_back_idle"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] held;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_type  = 3'd0;
    rs1       = 32'd0;
    rs2       = 32'd0;
    res_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_res",   {32'd0, res},       64'd0);
    chk("rst_zero",  {63'd0, zero},      64'd1);
    chk("rst_neg",   {63'd0, neg},       64'd0);
    chk("rst_busy",  {63'd0, busy},      64'd0);

    run_op("mul",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'd5, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'd7, 32'd100,      32'd7,        32'd2,        33);
    run_op("remu0",  3'd7, 32'd6,        32'd3,        32'd0,        33);
    run_op("div_z",  3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_z",  3'd6, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ov", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Backpressure: result must stay put while the consumer stalls.
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    wait_res(lat);
    chk("bp_lat", 64'(lat), 64'd33);
    held = res;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {63'd0, res_valid}, 64'd1);
      chk("bp_res",   {32'd0, res},       64'h00000000FFFFFFEB);
      chk("bp_neg",   {63'd0, neg},       64'd1);
      chk("bp_zero",  {63'd0, zero},      64'd0);
      chk("bp_ready", {63'd0, req_ready}, 64'd0);
    end
    chk("bp_held", {32'd0, res}, {32'd0, held});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_rel_busy",  {63'd0, busy},      64'd0);
    chk("bp_rel_ready", {63'd0, req_ready}, 64'd1);
    run_op("bp_next", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // Flush during iteration 10, with a competing request that must be dropped.
    issue(3'd5, 32'd1000, 32'd10);
    repeat (9) tick();
    chk("fl_busy_pre", {63'd0, busy}, 64'd1);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_type  = 3'd0;
    rs1       = 32'd3;
    rs2       = 32'd3;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("fl_busy",  {63'd0, busy},      64'd0);
    chk("fl_ready", {63'd0, req_ready}, 64'd1);
    chk("fl_valid", {63'd0, res_valid}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      chk("fl_novalid", {63'd0, res_valid | busy}, 64'd0);
    end
    run_op("fl_divu", 3'd5, 32'd9, 32'd3, 32'd3, 33);

    // Reset in the middle of CALC.
    issue(3'd0, 32'd5, 32'd6);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_ready", {63'd0, req_ready}, 64'd1);
    chk("mr_valid", {63'd0, res_valid}, 64'd0);
    chk("mr_res",   {32'd0, res},       64'd0);
    chk("mr_zero",  {63'd0, zero},      64'd1);
    chk("mr_neg",   {63'd0, neg},       64'd0);
    chk("mr_busy",  {63'd0, busy},      64'd0);
    run_op("mr_mul", 3'd0, 32'd5, 32'd6, 32'd30, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
